// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: controller state encoding, field constants,
// the inverse S-box table and the byte/row/field helper functions used by the
// inverse round datapath.
package aes_pkg;

  localparam int unsigned BLK_W   = 128;    // AES block width
  localparam int unsigned IDX_W   = 4;      // round-key index / round counter width
  localparam int unsigned NR      = 10;     // AES-128 round count
  localparam logic [7:0]  GF_POLY = 8'h1B;  // low byte of x^8+x^4+x^3+x+1 (0x11B)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte k (0..15) sits at [BLK_W-1-8k -: 8]; bytes are column-major.
  function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[BLK_W-1-8*k -: 8] = INV_SBOX[s[BLK_W-1-8*k -: 8]];
    end
    return r;
  endfunction

  // Row w rotates right by w columns: out[w][c] = in[w][(c-w) mod 4].
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[BLK_W-1-8*(4*c+w) -: 8] = s[BLK_W-1-8*(4*((c-w+4)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_Mix_Column.sv
// Combinational InvMixColumns over a full 128-bit state.
// Ports: state_in  - state after AddRoundKey (column-major, byte 0 at MSB)
//        state_out - each column multiplied by circulant [0E 0B 0D 09]
module inv_Mix_Column
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state_in,
  output logic [BLK_W-1:0] state_out
);

  // One column: a0 is the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      state_out[BLK_W-1-32*c -: 32] = mix_col(state_in[BLK_W-1-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per cycle, round
// keys fetched by index from an external store that answers combinationally.
// Ports: clk, rst_n (sync, active-low)
//        in_valid/in_ready/ct_in    - ciphertext input handshake
//        rk_idx/rk_data             - round-key request / returned key
//        out_valid/out_ready/pt_out - plaintext output handshake
//        busy                       - high whenever not IDLE
module aes_inv_round_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ct_in,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [BLK_W-1:0] rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] pt_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] round_cnt_q, round_cnt_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;

  logic [BLK_W-1:0] round_in_c;
  logic [BLK_W-1:0] mix_out_c;
  logic             accept_c;

  // Shared front half of both ROUND and FINAL: InvShiftRows, InvSubBytes, AddRoundKey.
  assign round_in_c = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_data;
  assign accept_c   = in_valid & in_ready_q;

  inv_Mix_Column u_inv_mix (
    .state_in  (round_in_c),
    .state_out (mix_out_c)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    data_d      = data_q;
    pt_d        = pt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          data_d      = ct_in ^ rk_data;
          round_cnt_d = IDX_W'(NR - 1);
          state_d     = ST_ROUND;
        end
      end
      ST_ROUND: begin
        data_d      = mix_out_c;
        round_cnt_d = round_cnt_q - IDX_W'(1);
        if (round_cnt_q == IDX_W'(1)) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        pt_d    = round_in_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are valid as flops.
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    case (state_d)
      ST_IDLE:  rk_idx_d = IDX_W'(NR);
      ST_ROUND: rk_idx_d = round_cnt_d;
      default:  rk_idx_d = '0;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_cnt_q <= '0;
      data_q      <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      rk_idx_q    <= IDX_W'(NR);
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      data_q      <= data_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign pt_out    = pt_q;
  assign rk_idx    = rk_idx_q;

endmodule
